// File: rtl/timer_bus_arb.sv
// Round-robin arbiter serialising NREQ requesters onto one timer32 register bus; TIMER_ARB_LOCK_EN adds a bus lock.
// Latency: gnt one cycle after req is sampled in IDLE; rsp_valid one cycle after gnt for writes, 1+RD_LAT for reads.
// Backpressure: req is a held level; one transaction in flight, later requests wait their round-robin turn.
module timer_bus_arb #(
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [2*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
`ifdef TIMER_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [31:0]          t_din,
    output logic [1:0]           t_addr,
    output logic                 t_wren,
    output logic                 t_rden,
    input  logic [31:0]          t_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   win, win_nxt;
    logic            cur_wr, cur_wr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [NREQ-1:0] gnt_nxt;
    logic [NREQ-1:0] rsp_valid_nxt;
    logic [31:0]     rsp_rdata_nxt;
    logic [31:0]     t_din_nxt;
    logic [1:0]      t_addr_nxt;
    logic            t_wren_nxt;
    logic            t_rden_nxt;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   pick;

`ifdef TIMER_ARB_LOCK_EN
    logic            lock_act, lock_act_nxt;
    logic [IW-1:0]   lock_idx, lock_idx_nxt;
    logic [NREQ-1:0] lock_mask;

    // While locked, only the lock holder may win the next IDLE arbitration.
    always_comb begin
        lock_mask           = '0;
        lock_mask[lock_idx] = 1'b1;
        elig                = lock_act ? (req & lock_mask) : req;
    end
`else
    always_comb begin
        elig = req;
    end
`endif

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_nxt       = win;
        cur_wr_nxt    = cur_wr;
        cnt_nxt       = cnt;
        gnt_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_rdata_nxt = rsp_rdata;
        t_din_nxt     = t_din;
        t_addr_nxt    = t_addr;
        t_wren_nxt    = 1'b0;
        t_rden_nxt    = 1'b0;
`ifdef TIMER_ARB_LOCK_EN
        lock_act_nxt  = lock_act;
        lock_idx_nxt  = lock_idx;
`endif
        unique case (state)
            IDLE: begin
`ifdef TIMER_ARB_LOCK_EN
                if (lock_act && !req[lock_idx]) begin
                    lock_act_nxt = 1'b0;
                end
`endif
                if (found) begin
                    // Payload is latched straight into the bus registers so later
                    // changes on the request side cannot disturb this transaction.
                    win_nxt       = pick;
                    cur_wr_nxt    = req_wr[pick];
                    t_addr_nxt    = req_addr[2*int'(pick) +: 2];
                    t_din_nxt     = req_wdata[32*int'(pick) +: 32];
                    t_wren_nxt    = req_wr[pick];
                    t_rden_nxt    = !req_wr[pick];
                    gnt_nxt[pick] = 1'b1;
                    state_nxt     = ISSUE;
`ifdef TIMER_ARB_LOCK_EN
                    lock_act_nxt  = req_lock[pick];
                    lock_idx_nxt  = pick;
`endif
                end
            end
            ISSUE: begin
                ptr_nxt = win;
                if (cur_wr) begin
                    rsp_valid_nxt[win] = 1'b1;
                    rsp_rdata_nxt      = '0;
                    state_nxt          = RESP;
                end else begin
                    cnt_nxt   = CW'(1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // cnt holds the number of cycles elapsed since the ISSUE cycle.
                if (cnt == CW'(RD_LAT)) begin
                    rsp_rdata_nxt      = t_dout;
                    rsp_valid_nxt[win] = 1'b1;
                    state_nxt          = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            win       <= '0;
            cur_wr    <= 1'b0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            t_din     <= '0;
            t_addr    <= '0;
            t_wren    <= 1'b0;
            t_rden    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            cur_wr    <= cur_wr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            t_din     <= t_din_nxt;
            t_addr    <= t_addr_nxt;
            t_wren    <= t_wren_nxt;
            t_rden    <= t_rden_nxt;
        end
    end

`ifdef TIMER_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_act <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock_act <= lock_act_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_timer_bus_arb.sv
// Self-checking bench for timer_bus_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_timer_bus_arb;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, req_wr;
    logic [2*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]  req_wdata;
`ifdef TIMER_ARB_LOCK_EN
    logic [NREQ-1:0]     req_lock;
`endif

    logic [NREQ-1:0] gnt1, rsp1, gnt3, rsp3;
    logic [31:0]     rdata1, rdata3, din1, din3, dout1, dout3;
    logic [1:0]      addr1, addr3;
    logic            wren1, rden1, wren3, rden3;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // transaction-level reference state
    logic [31:0] m_regs [4] = '{32'h10, 32'h11, 32'h4, 32'h13};
    int          m_ptr = NREQ - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_bus_arb #(.NREQ(NREQ), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef TIMER_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt1), .rsp_valid(rsp1), .rsp_rdata(rdata1), .t_din(din1), .t_addr(addr1),
        .t_wren(wren1), .t_rden(rden1), .t_dout(dout1));

    timer_bus_arb #(.NREQ(NREQ), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef TIMER_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt3), .rsp_valid(rsp3), .rsp_rdata(rdata3), .t_din(din3), .t_addr(addr3),
        .t_wren(wren3), .t_rden(rden3), .t_dout(dout3));

    // Timer register files: read data is valid only on the exact latency cycle, junk otherwise.
    logic [31:0] tregs1 [4] = '{32'h10, 32'h11, 32'h4, 32'h13};
    logic [31:0] tregs3 [4] = '{32'h10, 32'h11, 32'h4, 32'h13};
    logic [2:0]  vp1 = '0, vp3 = '0;
    logic [31:0] dp1 [3];
    logic [31:0] dp3 [3];

    always @(posedge clk) begin
        if (wren1) tregs1[addr1] <= din1;
        if (wren3) tregs3[addr3] <= din3;
        vp1 <= {vp1[1:0], rden1};
        vp3 <= {vp3[1:0], rden3};
        dp1[0] <= tregs1[addr1]; dp1[1] <= dp1[0]; dp1[2] <= dp1[1];
        dp3[0] <= tregs3[addr3]; dp3[1] <= dp3[0]; dp3[2] <= dp3[1];
    end
    assign dout1 = vp1[0] ? dp1[0] : {16'hdead, cyc[15:0]};
    assign dout3 = vp3[2] ? dp3[2] : {16'hbeef, cyc[15:0]};

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
        int r;
        r = -1;
        for (int k = NREQ; k >= 1; k--) begin
            if (m[(last + k) % NREQ]) r = (last + k) % NREQ;
        end
        return r;
    endfunction

    task automatic clr_req();
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
`ifdef TIMER_ARB_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic set_req(input int i, input logic wr, input logic [1:0] a, input logic [31:0] d);
        req[i] = 1'b1;
        req_wr[i] = wr;
        req_addr[2*i +: 2] = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clr_req();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr_req();
        repeat (3) @(negedge clk);
        n_checks++; if ({gnt1, rsp1, gnt3, rsp3} !== '0) $display("FAIL reset_strobes: got %h want 0", {gnt1, rsp1, gnt3, rsp3}); else n_pass++;
        n_checks++; if (rdata1 !== 32'h0 || rdata3 !== 32'h0) $display("FAIL reset_rdata: got %h/%h want 0", rdata1, rdata3); else n_pass++;
        n_checks++; if ({wren1, rden1, addr1, din1} !== '0) $display("FAIL reset_bus: got %b %b %h %h want 0", wren1, rden1, addr1, din1); else n_pass++;
        reset = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 2'b00, 32'h3);
        @(negedge clk);
        n_checks++; if (gnt1 !== 4'b0001) $display("FAIL wr_gnt: got %b want 0001", gnt1); else n_pass++;
        n_checks++; if ({wren1, rden1, addr1, din1} !== {1'b1, 1'b0, 2'b00, 32'h3})
            $display("FAIL wr_bus: got wren=%b rden=%b addr=%h din=%h want 1 0 0 3", wren1, rden1, addr1, din1); else n_pass++;
        clr_req();
        @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0001 || rdata1 !== 32'h0) $display("FAIL wr_rsp: got %b/%h want 0001/0", rsp1, rdata1); else n_pass++;
        n_checks++; if (gnt1 !== 4'b0000) $display("FAIL wr_gnt_pulse: got %b want 0000", gnt1); else n_pass++;
        m_regs[0] = 32'h3;
        m_ptr = 0;
        @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0000 || wren1 !== 1'b0) $display("FAIL wr_rsp_pulse: got %b wren %b want 0000 0", rsp1, wren1); else n_pass++;
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 2'b10, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt1 !== 4'b0100 || rden1 !== 1'b1 || wren1 !== 1'b0 || addr1 !== 2'b10)
            $display("FAIL rd_issue: got gnt=%b rden=%b wren=%b addr=%h want 0100 1 0 2", gnt1, rden1, wren1, addr1); else n_pass++;
        clr_req();
        @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0000 || rden1 !== 1'b0) $display("FAIL rd_wait: got rsp=%b rden=%b want 0000 0", rsp1, rden1); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0100 || rdata1 !== m_regs[2]) $display("FAIL rd_rsp: got %b/%h want 0100/%h", rsp1, rdata1, m_regs[2]); else n_pass++;
        m_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int ng, last_g, exp;
        logic [NREQ-1:0] prev_gnt, eh;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, 32'h100 + i);
        ng = 0; last_g = -1; prev_gnt = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt1 !== '0) begin
                exp = rr_pick(m_ptr, 4'b1111);
                eh = '0; eh[exp] = 1'b1;
                n_checks++; if (gnt1 !== eh || prev_gnt !== '0) $display("FAIL rr_order#%0d: got %b want %b", ng, gnt1, eh); else n_pass++;
                n_checks++; if (din1 !== 32'h100 + exp) $display("FAIL rr_din#%0d: got %h want %h", ng, din1, 32'h100 + exp); else n_pass++;
                if (last_g >= 0) begin
                    n_checks++; if (cyc - last_g !== 3) $display("FAIL rr_spacing#%0d: got %0d want 3", ng, cyc - last_g); else n_pass++;
                end
                last_g = cyc; m_ptr = exp; m_regs[0] = 32'h100 + exp;
                ng++;
                if (ng == 6) clr_req();
            end
            prev_gnt = gnt1;
        end
        n_checks++; if (ng !== 6) $display("FAIL rr_count: got %0d grants want 6", ng); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_req(3, 1'b0, 2'b10, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt1 !== 4'b1000) $display("FAIL rm_gnt: got %b want 1000", gnt1); else n_pass++;
        clr_req();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({gnt1, rsp1, wren1, rden1, addr1, din1, rdata1} !== '0)
            $display("FAIL rm_outputs: got gnt=%b rsp=%b wr=%b rd=%b addr=%h din=%h rdata=%h want all 0", gnt1, rsp1, wren1, rden1, addr1, din1, rdata1); else n_pass++;
        reset = 1'b0;
        m_ptr = NREQ - 1;
        set_req(0, 1'b0, 2'b01, 32'h0);
        set_req(1, 1'b0, 2'b01, 32'h0);
        @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0000) $display("FAIL rm_no_rsp: got %b want 0000", rsp1); else n_pass++;
        n_checks++; if (gnt1 !== 4'b0001) $display("FAIL rm_first: got %b want 0001", gnt1); else n_pass++;
        clr_req();
        repeat (2) @(negedge clk);
        n_checks++; if (rsp1 !== 4'b0001 || rdata1 !== m_regs[1]) $display("FAIL rm_rsp: got %b/%h want 0001/%h", rsp1, rdata1, m_regs[1]); else n_pass++;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_rd_lat3();
        do_reset();
        set_req(1, 1'b0, 2'b01, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt3 !== 4'b0010 || rden3 !== 1'b1) $display("FAIL l3_issue: got gnt=%b rden=%b want 0010 1", gnt3, rden3); else n_pass++;
        clr_req();
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                n_checks++; if (rsp3 !== 4'b0000) $display("FAIL l3_early@%0d: got %b want 0000", k, rsp3); else n_pass++;
            end else begin
                n_checks++; if (rsp3 !== 4'b0010 || rdata3 !== m_regs[1]) $display("FAIL l3_rsp: got %b/%h want 0010/%h", rsp3, rdata3, m_regs[1]); else n_pass++;
            end
        end
        m_ptr = 1;
        repeat (2) @(negedge clk);
    endtask

`ifdef TIMER_ARB_LOCK_EN
    task automatic test_lock();
        int ng;
        int order [4];
        int want [4] = '{1, 1, 3, 0};
        do_reset();
        set_req(0, 1'b1, 2'b00, 32'h55);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 32'hA0);
        set_req(3, 1'b1, 2'b00, 32'hA3);
        set_req(1, 1'b0, 2'b00, 32'h0);
        req_lock[1] = 1'b1;
        ng = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt1 !== '0 && ng < 4) begin
                order[ng] = (gnt1 == 4'b0001) ? 0 : (gnt1 == 4'b0010) ? 1 : (gnt1 == 4'b0100) ? 2 : (gnt1 == 4'b1000) ? 3 : -1;
                if (ng == 0) begin set_req(1, 1'b1, 2'b00, 32'hB1); req_lock[1] = 1'b0; end
                if (ng == 1) req[1] = 1'b0;
                ng++;
                if (ng == 4) clr_req();
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ng <= i || order[i] !== want[i]) $display("FAIL lock_order#%0d: got %0d want %0d", i, (ng > i) ? order[i] : -1, want[i]); else n_pass++;
        end
        m_regs[0] = 32'hA0;
        m_ptr = 0;
    endtask
`endif

    task automatic test_random();
        int out_idx, out_cyc, exp, max_wait;
        logic [31:0] out_data;
        logic [NREQ-1:0] busy, prev_req, eh;
        int wait_cnt [NREQ];
        out_idx = -1; out_cyc = 0; out_data = '0; max_wait = 0;
        busy = '0; prev_req = '0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        clr_req();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (gnt1 !== '0) begin
                exp = (out_idx >= 0) ? -1 : rr_pick(m_ptr, prev_req);
                eh = '0;
                if (exp >= 0) eh[exp] = 1'b1;
                n_checks++;
                if (exp < 0 || gnt1 !== eh) begin
                    $display("FAIL rand_gnt@%0d: got %b want %b", cyc, gnt1, eh);
                end else begin
                    n_pass++;
                    n_checks++;
                    if (wren1 !== req_wr[exp] || rden1 !== !req_wr[exp] || addr1 !== req_addr[2*exp +: 2] ||
                        (req_wr[exp] && din1 !== req_wdata[32*exp +: 32]))
                        $display("FAIL rand_bus@%0d: got wr=%b rd=%b addr=%h din=%h want wr=%b addr=%h din=%h", cyc, wren1, rden1, addr1, din1,
                                 req_wr[exp], req_addr[2*exp +: 2], req_wdata[32*exp +: 32]);
                    else n_pass++;
                    out_idx = exp;
                    out_cyc = cyc + (req_wr[exp] ? 1 : 2);
                    out_data = req_wr[exp] ? 32'h0 : m_regs[req_addr[2*exp +: 2]];
                    if (req_wr[exp]) m_regs[req_addr[2*exp +: 2]] = req_wdata[32*exp +: 32];
                    m_ptr = exp;
                    req[exp] = 1'b0;
                end
            end
            if (out_idx >= 0 && cyc == out_cyc) begin
                eh = '0; eh[out_idx] = 1'b1;
                n_checks++; if (rsp1 !== eh || rdata1 !== out_data) $display("FAIL rand_rsp@%0d: got %b/%h want %b/%h", cyc, rsp1, rdata1, eh, out_data); else n_pass++;
                busy[out_idx] = 1'b0;
                out_idx = -1;
            end else if (rsp1 !== '0) begin
                n_checks++;
                $display("FAIL rand_stray_rsp@%0d: got %b want 0000", cyc, rsp1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            if (k < 1400) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!busy[i] && $urandom_range(0, 3) == 0) begin
                        busy[i] = 1'b1;
                        wait_cnt[i] = 0;
                        set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
                    end
                end
            end
            prev_req = req;
        end
        n_checks++; if (busy !== '0 || out_idx != -1) $display("FAIL rand_drain: got busy=%b outstanding=%0d want 0/-1", busy, out_idx); else n_pass++;
        n_checks++; if (max_wait > NREQ * 4 + 4) $display("FAIL rand_starve: got max wait %0d want <= %0d", max_wait, NREQ * 4 + 4); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        clr_req();
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_reset_mid();
        test_rd_lat3();
`ifdef TIMER_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
